// File: rtl/rf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_if
//
// Bundle between the write-back requesters and the register-file write-back
// arbiter.
//
// Parameters
//   WordSize : width of the register-file write data
//   NumReq   : number of write-back requesters (2..8)
//
// Signals
//   wbEnable : global write-back enable; 0 freezes all acceptance
//   reqValid : per-requester write request
//   reqDst   : per-requester destination register index (5 bits each)
//   reqData  : per-requester write data (WordSize bits each)
//   reqReady : per-requester acceptance, combinational, one-hot or zero
//   rfWe     : registered register-file write enable
//   rfDst    : registered register-file destination index
//   rfData   : registered register-file write data
//   rfSrc    : registered index of the requester behind the current rfWe
//
// Modports
//   master : requester side (drives requests, observes acceptance and rf port)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface rf_wb_arbiter_if #(
    parameter int WordSize = 32,
    parameter int NumReq   = 2
);
    localparam int SrcW = $clog2(NumReq);

    logic                               wbEnable;
    logic [NumReq-1:0]                  reqValid;
    logic [NumReq-1:0][4:0]             reqDst;
    logic [NumReq-1:0][WordSize-1:0]    reqData;
    logic [NumReq-1:0]                  reqReady;
    logic                               rfWe;
    logic [4:0]                         rfDst;
    logic [WordSize-1:0]                rfData;
    logic [SrcW-1:0]                    rfSrc;

    modport master (
        output wbEnable,
        output reqValid,
        output reqDst,
        output reqData,
        input  reqReady,
        input  rfWe,
        input  rfDst,
        input  rfData,
        input  rfSrc
    );

    modport slave (
        input  wbEnable,
        input  reqValid,
        input  reqDst,
        input  reqData,
        output reqReady,
        output rfWe,
        output rfDst,
        output rfData,
        output rfSrc
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Arbitrates up to NumReq write-back requesters onto the single register-file
// write port. At most one request is accepted per cycle; the accepted request
// appears on the registered rf* outputs one cycle later. Writes to x0 are
// accepted but produce no rfWe pulse.
//
// Configuration macro
//   RF_WB_ARB_RR_EN : defined   -> round-robin, search starts after the last
//                                  accepted requester (pointer resets to
//                                  NumReq-1 so requester 0 goes first)
//                     undefined -> fixed priority, lowest index wins, no
//                                  pointer state
//
// Ports
//   clk    : clock, rising edge
//   nReset : asynchronous, active-low reset
//   bus    : rf_wb_arbiter_if.slave (requests in, acceptance and rf port out)
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int WordSize = 32,
    parameter int NumReq   = 2
) (
    input  logic              clk,
    input  logic              nReset,
    rf_wb_arbiter_if.slave    bus
);

    localparam int SrcW = $clog2(NumReq);

    // Arbitration result (before wbEnable gating)
    logic [NumReq-1:0]      grant_s;
    logic [SrcW-1:0]        grant_idx_s;
    logic                   grant_any_s;
    logic                   xfer_s;

    // Registered register-file port
    logic                   rf_we_q;
    logic                   rf_we_d;
    logic [4:0]             rf_dst_q;
    logic [4:0]             rf_dst_d;
    logic [WordSize-1:0]    rf_data_q;
    logic [WordSize-1:0]    rf_data_d;
    logic [SrcW-1:0]        rf_src_q;
    logic [SrcW-1:0]        rf_src_d;

`ifdef RF_WB_ARB_RR_EN
    // Round-robin pointer: index of the last accepted requester
    logic [SrcW-1:0]        last_q;
    logic [SrcW-1:0]        last_d;

    // Round-robin search: walk from last_q+1 around to last_q, first valid wins.
    // cand_v carries one extra bit so last_q + k never overflows before the wrap.
    always_comb begin : rr_search
        logic [SrcW:0] cand_v;
        logic          hit_v;
        cand_v      = '0;
        hit_v       = 1'b0;
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        for (int k = 1; k <= NumReq; k++) begin
            cand_v = {1'b0, last_q} + (SrcW+1)'(k);
            if (cand_v >= (SrcW+1)'(NumReq)) begin
                cand_v = cand_v - (SrcW+1)'(NumReq);
            end else begin
                cand_v = cand_v;
            end
            hit_v       = !grant_any_s && bus.reqValid[cand_v[SrcW-1:0]];
            grant_idx_s = hit_v ? cand_v[SrcW-1:0] : grant_idx_s;
            grant_any_s = grant_any_s | hit_v;
        end
    end

    // Pointer next state: advances only on a completed transfer
    always_comb begin
        last_d = last_q;
        if (xfer_s) begin
            last_d = grant_idx_s;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset value makes requester 0 the first candidate
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            last_q <= SrcW'(NumReq - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: scan from the top down so the lowest valid index wins
    always_comb begin
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            grant_idx_s = bus.reqValid[k] ? SrcW'(k) : grant_idx_s;
            grant_any_s = grant_any_s | bus.reqValid[k];
        end
    end
`endif

    // One-hot expansion of the winning index
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < NumReq; i++) begin
            grant_s[i] = grant_any_s && (grant_idx_s == SrcW'(i));
        end
    end

    // A transfer needs a winner and an open gate; reset also closes the gate
    // so reqReady stays low while nReset is asserted.
    assign xfer_s       = grant_any_s && bus.wbEnable && nReset;
    assign bus.reqReady = grant_s & {NumReq{bus.wbEnable && nReset}};

    // Register-file port next state: capture on transfer, hold otherwise.
    // A destination of x0 is still a transfer but never pulses the write enable.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_dst_d  = rf_dst_q;
        rf_data_d = rf_data_q;
        rf_src_d  = rf_src_q;
        if (xfer_s) begin
            rf_we_d   = (bus.reqDst[grant_idx_s] != 5'd0);
            rf_dst_d  = bus.reqDst[grant_idx_s];
            rf_data_d = bus.reqData[grant_idx_s];
            rf_src_d  = grant_idx_s;
        end else begin
            rf_we_d   = 1'b0;
        end
    end

    // Register-file port registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rf_we_q   <= 1'b0;
            rf_dst_q  <= 5'd0;
            rf_data_q <= '0;
            rf_src_q  <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_dst_q  <= rf_dst_d;
            rf_data_q <= rf_data_d;
            rf_src_q  <= rf_src_d;
        end
    end

    assign bus.rfWe   = rf_we_q;
    assign bus.rfDst  = rf_dst_q;
    assign bus.rfData = rf_data_q;
    assign bus.rfSrc  = rf_src_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Directed bench for rf_wb_arbiter with two requesters. Expected values are
// hand-computed; where round-robin and fixed priority differ, both are given
// and selected by RF_WB_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

`ifdef RF_WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic nReset;
    int   n_checks;
    int   n_fail;

    rf_wb_arbiter_if #(.WordSize(32), .NumReq(2)) bus ();

    rf_wb_arbiter #(.WordSize(32), .NumReq(2)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nReset        = 1'b0;
        bus.wbEnable  = 1'b1;
        bus.reqValid  = 2'b11;
        bus.reqDst[0] = 5'd7;
        bus.reqDst[1] = 5'd8;
        bus.reqData[0] = 32'h1111_1111;
        bus.reqData[1] = 32'h2222_2222;

        // Reset state, with requests pending during reset
        step();
        step();
        chk("rst_ready", 64'(bus.reqReady), 64'd0);
        chk("rst_we",    64'(bus.rfWe),     64'd0);
        chk("rst_dst",   64'(bus.rfDst),    64'd0);
        chk("rst_data",  64'(bus.rfData),   64'd0);
        chk("rst_src",   64'(bus.rfSrc),    64'd0);

        // Single request from requester 0
        bus.reqValid = 2'b00;
        nReset = 1'b1;
        step();
        chk("idle_we", 64'(bus.rfWe), 64'd0);
        bus.reqValid   = 2'b01;
        bus.reqDst[0]  = 5'd5;
        bus.reqData[0] = 32'hDEAD_BEEF;
        #1;
        chk("single_ready", 64'(bus.reqReady), 64'd1);
        step();
        bus.reqValid = 2'b00;
        chk("single_we",   64'(bus.rfWe),   64'd1);
        chk("single_dst",  64'(bus.rfDst),  64'd5);
        chk("single_data", 64'(bus.rfData), 64'hDEAD_BEEF);
        chk("single_src",  64'(bus.rfSrc),  64'd0);
        step();
        chk("single_we_off", 64'(bus.rfWe),  64'd0);
        chk("single_hold",   64'(bus.rfDst), 64'd5);

        // Contention from reset: both valid continuously
        nReset = 1'b0;
        #1;
        bus.reqValid   = 2'b11;
        bus.reqDst[0]  = 5'd3;
        bus.reqDst[1]  = 5'd4;
        bus.reqData[0] = 32'hA0A0_A0A0;
        bus.reqData[1] = 32'hA1A1_A1A1;
        #1;
        nReset = 1'b1;
        #1;
        // expected grant order: RR 0,1,0 ; fixed 0,0,0
        chk("cont0_ready", 64'(bus.reqReady), 64'd1);
        step();
        chk("cont0_we",  64'(bus.rfWe),  64'd1);
        chk("cont0_src", 64'(bus.rfSrc), 64'd0);
        chk("cont0_dst", 64'(bus.rfDst), 64'd3);
        chk("cont1_ready", 64'(bus.reqReady), RR ? 64'd2 : 64'd1);
        step();
        chk("cont1_we",   64'(bus.rfWe),   64'd1);
        chk("cont1_src",  64'(bus.rfSrc),  RR ? 64'd1 : 64'd0);
        chk("cont1_data", 64'(bus.rfData), RR ? 64'hA1A1_A1A1 : 64'hA0A0_A0A0);
        step();
        chk("cont2_we",  64'(bus.rfWe),  64'd1);
        chk("cont2_src", 64'(bus.rfSrc), 64'd0);

        // Freeze for 3 cycles with both valid
        bus.wbEnable = 1'b0;
        #1;
        chk("frz_ready", 64'(bus.reqReady), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_we",  64'(bus.rfWe),  64'd0);
            chk("frz_src", 64'(bus.rfSrc), 64'd0);
        end
        bus.wbEnable = 1'b1;
        #1;
        chk("unfrz_ready", 64'(bus.reqReady), RR ? 64'd2 : 64'd1);
        step();
        chk("unfrz_we",  64'(bus.rfWe),  64'd1);
        chk("unfrz_src", 64'(bus.rfSrc), RR ? 64'd1 : 64'd0);

        // x0 drop from requester 1
        bus.reqValid   = 2'b10;
        bus.reqDst[1]  = 5'd0;
        bus.reqData[1] = 32'h1234_5678;
        #1;
        chk("x0_ready", 64'(bus.reqReady), 64'd2);
        step();
        chk("x0_we", 64'(bus.rfWe), 64'd0);
        bus.reqValid   = 2'b11;
        bus.reqDst[1]  = 5'd4;
        bus.reqData[1] = 32'hA1A1_A1A1;
        #1;
        chk("x0_next_ready", 64'(bus.reqReady), 64'd1);
        step();
        chk("x0_next_we",  64'(bus.rfWe),  64'd1);
        chk("x0_next_src", 64'(bus.rfSrc), 64'd0);
        step();
        chk("b2b_we",   64'(bus.rfWe),   64'd1);
        chk("b2b_src",  64'(bus.rfSrc),  RR ? 64'd1 : 64'd0);

        // Asynchronous reset pulse between edges during back-to-back traffic
        #2;
        nReset = 1'b0;
        #1;
        chk("arst_we",    64'(bus.rfWe),     64'd0);
        chk("arst_dst",   64'(bus.rfDst),    64'd0);
        chk("arst_data",  64'(bus.rfData),   64'd0);
        chk("arst_src",   64'(bus.rfSrc),    64'd0);
        chk("arst_ready", 64'(bus.reqReady), 64'd0);
        bus.reqValid = 2'b00;
        #1;
        nReset = 1'b1;
        step();
        chk("arst_no_pulse", 64'(bus.rfWe), 64'd0);
        bus.reqValid = 2'b11;
        #1;
        chk("arst_first_ready", 64'(bus.reqReady), 64'd1);
        step();
        chk("arst_first_we",  64'(bus.rfWe),  64'd1);
        chk("arst_first_src", 64'(bus.rfSrc), 64'd0);
        chk("arst_first_dst", 64'(bus.rfDst), 64'd3);
        bus.reqValid = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
